// File: rtl/tff_count_sequencer.sv
// tff_count_sequencer
//
// Sequences an external bank of WIDTH T flip-flops that forms a synchronous
// counter. The count lives only in the bank; this block reads it back on
// q_in and decides which flip-flops toggle on each edge through t_out.
//
// Handshake: a command transfers on a rising edge where cmd_valid=1,
// cmd_ready=1 and rst=1. cmd_ready is only high in IDLE, commands are not
// queued, and a master that sees cmd_ready=0 must keep cmd_valid asserted.
//
// Ports:
//   clk        clock shared with the T flip-flop bank
//   rst        synchronous active-low reset
//   cmd_valid  command present
//   cmd_ready  block can accept a command (registered)
//   cmd_op     00 up, 01 down, 10 load, 11 clear
//   cmd_steps  step count for up/down
//   cmd_data   load value
//   hold       pauses a running up/down command
//   q_in       Q outputs of the bank, bit 0 = LSB
//   t_out      T inputs of the bank (combinational)
//   busy       command in progress (registered)
//   done       one-cycle pulse on command completion (registered)
//   wrap       one-cycle pulse after a wrapping up/down step (registered)
module tff_count_sequencer #(
    parameter int WIDTH  = 3,
    parameter int STEP_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [STEP_W-1:0] cmd_steps,
    input  logic [WIDTH-1:0]  cmd_data,
    input  logic              hold,
    input  logic [WIDTH-1:0]  q_in,
    output logic [WIDTH-1:0]  t_out,
    output logic              busy,
    output logic              done,
    output logic              wrap
);

    localparam logic [1:0] OP_UP   = 2'b00;
    localparam logic [1:0] OP_DOWN = 2'b01;
    localparam logic [1:0] OP_LOAD = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        APPLY = 2'b10,
        DONE  = 2'b11
    } state_t;

    state_t            state;
    logic [1:0]        op_r;
    logic [WIDTH-1:0]  data_r;
    logic [STEP_W-1:0] remaining;

    logic [WIDTH-1:0]  up_t;
    logic [WIDTH-1:0]  dn_t;

    // Ripple-carry toggle masks: bit i toggles when every lower bit is 1
    // (counting up) or every lower bit is 0 (counting down).
    always_comb begin
        logic acc_u;
        logic acc_d;
        acc_u = 1'b1;
        acc_d = 1'b1;
        up_t  = '0;
        dn_t  = '0;
        for (int i = 0; i < WIDTH; i++) begin
            up_t[i] = acc_u;
            dn_t[i] = acc_d;
            acc_u   = acc_u & q_in[i];
            acc_d   = acc_d & ~q_in[i];
        end
    end

    // t_out is forced low during reset so the bank holds its value.
    always_comb begin
        t_out = '0;
        if (rst) begin
            case (state)
                RUN: begin
                    if (!hold) begin
                        t_out = (op_r == OP_DOWN) ? dn_t : up_t;
                    end
                end
                // Load toggles the bits that differ from the target;
                // clear toggles every bit that is currently 1.
                APPLY: t_out = (op_r == OP_LOAD) ? (q_in ^ data_r) : q_in;
                default: t_out = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            op_r      <= OP_UP;
            data_r    <= '0;
            remaining <= '0;
            cmd_ready <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            wrap      <= 1'b0;
        end else begin
            done <= 1'b0;
            wrap <= 1'b0;
            case (state)
                IDLE: begin
                    cmd_ready <= 1'b1;
                    if (cmd_valid && cmd_ready) begin
                        op_r      <= cmd_op;
                        data_r    <= cmd_data;
                        remaining <= cmd_steps;
                        cmd_ready <= 1'b0;
                        busy      <= 1'b1;
                        if (cmd_op[1]) begin
                            state <= APPLY;
                        end else if (cmd_steps == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (!hold) begin
                        remaining <= remaining - STEP_W'(1);
                        wrap      <= (op_r == OP_DOWN) ? ~|q_in : &q_in;
                        if (remaining == STEP_W'(1)) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                APPLY: begin
                    state <= DONE;
                    done  <= 1'b1;
                end
                DONE: begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    cmd_ready <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
